// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS execute/memory block:
// opcodes, R-type functs, ALU operation codes, extender modes and the control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_SLLV  = 5'd11;
  localparam logic [4:0] ALU_SRLV  = 5'd12;
  localparam logic [4:0] ALU_SRAV  = 5'd13;
  localparam logic [4:0] ALU_PASSB = 5'd14;
  localparam logic [4:0] ALU_EQ    = 5'd15;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef struct packed {
    logic       jump;
    logic       reg_dst;
    logic       branch;
    logic       mem_r;
    logic       mem2r;
    logic       mem_w;
    logic       reg_w;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [4:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{default: '0};

endpackage

// File: rtl/mips_exec_stage_if.sv
// Instruction fields, operands and results exchanged between the core and the execute stage.
interface mips_exec_stage_if;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] ExtImm;
  logic        Jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, AluSrc;
  logic [1:0]  ExtOp;
  logic [4:0]  AluCtrl;
  logic [31:0] AluResult;
  logic        Zero;
  logic [31:0] WbData;

  modport master (
    output OpCode, Funct, Shamt, RsData, RtData, ExtImm,
    input  Jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, AluSrc,
    input  ExtOp, AluCtrl, AluResult, Zero, WbData
  );

  modport slave (
    input  OpCode, Funct, Shamt, RsData, RtData, ExtImm,
    output Jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, AluSrc,
    output ExtOp, AluCtrl, AluResult, Zero, WbData
  );
endinterface

// File: rtl/mips_alu.sv
// 32-bit ALU; shifts operate on B with either the instruction shamt or A[4:0].
module mips_alu
  import mips_pkg::*;
(
  input  logic [4:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  logic [4:0] vsh;
  assign vsh = a[4:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_SLL:   result = b << shamt;
      ALU_SRL:   result = b >> shamt;
      ALU_SRA:   result = $unsigned($signed(b) >>> shamt);
      ALU_SLLV:  result = b << vsh;
      ALU_SRLV:  result = b >> vsh;
      ALU_SRAV:  result = $unsigned($signed(b) >>> vsh);
      ALU_PASSB: result = b;
      ALU_EQ:    result = {31'd0, a == b};
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decoder.sv
// Main control decoder: opcode/funct to datapath controls and ALU operation.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (op_code)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_w   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl.alu_ctrl = ALU_AND;
          FN_OR:           ctrl.alu_ctrl = ALU_OR;
          FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
          FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
          FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
          FN_SLTU:         ctrl.alu_ctrl = ALU_SLTU;
          FN_SLL:          ctrl.alu_ctrl = ALU_SLL;
          FN_SRL:          ctrl.alu_ctrl = ALU_SRL;
          FN_SRA:          ctrl.alu_ctrl = ALU_SRA;
          FN_SLLV:         ctrl.alu_ctrl = ALU_SLLV;
          FN_SRLV:         ctrl.alu_ctrl = ALU_SRLV;
          FN_SRAV:         ctrl.alu_ctrl = ALU_SRAV;
          // an unrecognised funct must not write the register file
          default:         ctrl = CTRL_NOP;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.alu_ctrl = ALU_ADD;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.alu_ctrl = (op_code == OP_SLTI) ? ALU_SLT : ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.ext_op  = EXT_ZERO;
        ctrl.alu_ctrl = (op_code == OP_ANDI) ? ALU_AND :
                        (op_code == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.ext_op  = EXT_LUI;
        ctrl.alu_ctrl = ALU_PASSB;
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_r   = 1'b1;
        ctrl.mem2r   = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_w   = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch  = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        // bne uses EQ so that Zero is set exactly when the branch is taken
        ctrl.alu_ctrl = (op_code == OP_BEQ) ? ALU_SUB : ALU_EQ;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/mips_dmem.sv
// Word-addressed data memory: async-clear array, clocked writes, combinational gated reads.
module mips_dmem #(
  parameter int DM_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DM_AW-1:0] addr,
  input  logic             re,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int DEPTH = 1 << DM_AW;

  logic [DEPTH-1:0][31:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = re ? mem[addr] : 32'd0;

endmodule

// File: rtl/mips_exec_stage.sv
// Single-cycle execute/memory stage: decode, ALU, data memory and write-back select.
module mips_exec_stage
  import mips_pkg::*;
#(
  parameter int DM_AW = 5
) (
  input  logic                Clk,
  input  logic                Reset,
  mips_exec_stage_if.slave    bus
);

  ctrl_t       ctrl;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_rdata;

  mips_decoder u_dec (
    .op_code (bus.OpCode),
    .funct   (bus.Funct),
    .ctrl    (ctrl)
  );

  assign alu_b = ctrl.alu_src ? bus.ExtImm : bus.RtData;

  mips_alu u_alu (
    .alu_ctrl (ctrl.alu_ctrl),
    .a        (bus.RsData),
    .b        (alu_b),
    .shamt    (bus.Shamt),
    .result   (alu_result),
    .zero     (zero)
  );

  mips_dmem #(.DM_AW(DM_AW)) u_dmem (
    .clk   (Clk),
    .rst   (Reset),
    .addr  (alu_result[DM_AW-1:0]),
    .re    (ctrl.mem_r),
    .we    (ctrl.mem_w),
    .wdata (bus.RtData),
    .rdata (mem_rdata)
  );

  assign bus.Jump      = ctrl.jump;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.Branch    = ctrl.branch;
  assign bus.MemR      = ctrl.mem_r;
  assign bus.Mem2R     = ctrl.mem2r;
  assign bus.MemW      = ctrl.mem_w;
  assign bus.RegW      = ctrl.reg_w;
  assign bus.AluSrc    = ctrl.alu_src;
  assign bus.ExtOp     = ctrl.ext_op;
  assign bus.AluCtrl   = ctrl.alu_ctrl;
  assign bus.AluResult = alu_result;
  assign bus.Zero      = zero;
  assign bus.WbData    = ctrl.mem2r ? mem_rdata : alu_result;

endmodule

// File: tb/tb_mips_exec_stage.sv
// Directed bench for mips_exec_stage: hand-computed controls, ALU results and memory traffic.
module tb_mips_exec_stage;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mips_exec_stage_if bus ();

  mips_exec_stage #(.DM_AW(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // {Jump,RegDst,Branch,MemR,Mem2R,MemW,RegW,AluSrc,ExtOp,AluCtrl}
  logic [14:0] ctrl_obs;
  assign ctrl_obs = {bus.Jump, bus.RegDst, bus.Branch, bus.MemR, bus.Mem2R,
                     bus.MemW, bus.RegW, bus.AluSrc, bus.ExtOp, bus.AluCtrl};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
    @(negedge Clk);
    bus.OpCode = op;
    bus.Funct  = fn;
    bus.Shamt  = sh;
    bus.RsData = rs;
    bus.RtData = rt;
    bus.ExtImm = imm;
    #1;
  endtask

  initial begin
    bus.OpCode = 6'd0; bus.Funct = 6'd0; bus.Shamt = 5'd0;
    bus.RsData = 32'd0; bus.RtData = 32'd0; bus.ExtImm = 32'd0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // memory clear after reset: lw from word 12
    drive(6'b100011, 6'd0, 5'd0, 32'd0, 32'd0, 32'd12);
    check("reset_mem_rd", bus.WbData, 32'd0);
    check("lw_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0001_1011, 2'b01, 5'd0});

    // addi 5 + (-3)
    drive(6'b001000, 6'd0, 5'd0, 32'd5, 32'd0, 32'hFFFF_FFFD);
    check("addi_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0000_0011, 2'b01, 5'd0});
    check("addi_res", bus.AluResult, 32'd2);
    check("addi_wb", bus.WbData, 32'd2);
    check("addi_zero", {31'd0, bus.Zero}, 32'd0);

    // sw 0xDEADBEEF to 4+8; write happens at the following edge
    drive(6'b101011, 6'd0, 5'd0, 32'd4, 32'hDEAD_BEEF, 32'd8);
    check("sw_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0000_0101, 2'b01, 5'd0});
    check("sw_addr", bus.AluResult, 32'd12);
    // second store to word 20 to catch address aliasing
    drive(6'b101011, 6'd0, 5'd0, 32'd0, 32'h1234_5678, 32'd20);
    drive(6'b100011, 6'd0, 5'd0, 32'd4, 32'd0, 32'd8);
    check("lw_after_sw", bus.WbData, 32'hDEAD_BEEF);
    check("lw_mem2r", {31'd0, bus.Mem2R}, 32'd1);
    drive(6'b100011, 6'd0, 5'd0, 32'd0, 32'd0, 32'd20);
    check("lw_word20", bus.WbData, 32'h1234_5678);

    // async reset clears memory without a clock edge
    drive(6'b100011, 6'd0, 5'd0, 32'd4, 32'd0, 32'd8);
    Reset = 1'b1;
    #1;
    check("reset_async_clr", bus.WbData, 32'd0);
    // reset overrides a store across an edge
    drive(6'b101011, 6'd0, 5'd0, 32'd4, 32'hCAFE_F00D, 32'd8);
    @(posedge Clk);
    #1 Reset = 1'b0;
    drive(6'b100011, 6'd0, 5'd0, 32'd4, 32'd0, 32'd8);
    check("reset_over_sw", bus.WbData, 32'd0);

    // beq A==B
    drive(6'b000100, 6'd0, 5'd0, 32'd7, 32'd7, 32'd0);
    check("beq_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0010_0000, 2'b01, 5'd1});
    check("beq_zero", {31'd0, bus.Zero}, 32'd1);
    // bne equal then unequal
    drive(6'b000101, 6'd0, 5'd0, 32'd7, 32'd7, 32'd0);
    check("bne_eq_zero", {31'd0, bus.Zero}, 32'd0);
    check("bne_eq_res", bus.AluResult, 32'd1);
    drive(6'b000101, 6'd0, 5'd0, 32'd7, 32'd8, 32'd0);
    check("bne_ne_zero", {31'd0, bus.Zero}, 32'd1);

    // sra by shamt
    drive(6'b000000, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 32'd0);
    check("sra_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0100_0010, 2'b00, 5'd10});
    check("sra_res", bus.AluResult, 32'hF800_0000);
    // srav uses A[4:0] only
    drive(6'b000000, 6'b000111, 5'd0, 32'h0000_0024, 32'h8000_0000, 32'd0);
    check("srav_res", bus.AluResult, 32'hF800_0000);
    drive(6'b000000, 6'b000100, 5'd0, 32'd4, 32'd1, 32'd0);
    check("sllv_res", bus.AluResult, 32'd16);
    drive(6'b000000, 6'b000010, 5'd8, 32'd0, 32'h8000_0000, 32'd0);
    check("srl_res", bus.AluResult, 32'h0080_0000);
    drive(6'b000000, 6'b100111, 5'd0, 32'd0, 32'd0, 32'd0);
    check("nor_res", bus.AluResult, 32'hFFFF_FFFF);

    // sltu vs slt on 1 vs 0xFFFFFFFF
    drive(6'b000000, 6'b101011, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    check("sltu_res", bus.AluResult, 32'd1);
    drive(6'b000000, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    check("slt_res", bus.AluResult, 32'd0);

    // andi: zero-ext, immediate as B
    drive(6'b001100, 6'd0, 5'd0, 32'h0000_FF0F, 32'hFFFF_FFFF, 32'h0000_0FF0);
    check("andi_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0000_0011, 2'b00, 5'd2});
    check("andi_res", bus.AluResult, 32'h0000_0F00);

    // lui passes B
    drive(6'b001111, 6'd0, 5'd0, 32'hAAAA_AAAA, 32'd0, 32'h1234_0000);
    check("lui_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b0000_0011, 2'b10, 5'd14});
    check("lui_res", bus.AluResult, 32'h1234_0000);

    // j
    drive(6'b000010, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check("j_ctrl", {17'd0, ctrl_obs}, {17'd0, 8'b1000_0000, 2'b00, 5'd0});

    // unknown opcode and unknown R-type funct
    drive(6'b111111, 6'd0, 5'd0, 32'd3, 32'd4, 32'd5);
    check("unk_op_ctrl", {17'd0, ctrl_obs}, 32'd0);
    drive(6'b000000, 6'b111111, 5'd0, 32'd3, 32'd4, 32'd5);
    check("unk_fn_ctrl", {17'd0, ctrl_obs}, 32'd0);
    check("unk_fn_res", bus.AluResult, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_exec_stage.md
# mips_exec_stage

Combinational MIPS single-cycle execute/memory block: main decoder (`Ctrl`), 32-bit ALU (`Alu`) and a 32x32 data memory (`DMem`). It sits between the register file/extender and the write-back mux of the single-cycle core. It decodes the instruction fields, computes the ALU result and `Zero`, and performs loads and stores. It returns the write-back value (`WbData`).

## Interface
- `DM_AW`, default 5: data-memory word-address width (32 words); address = `AluResult[DM_AW-1:0]`.
- `Clk`  in  1  clock; memory writes on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all memory words to 0.
- `OpCode`  in  6  instr[31:26].
- `Funct`  in  6  instr[5:0].
- `Shamt`  in  5  instr[10:6].
- `RsData`  in  32  GPR read port 1 (rs); ALU operand A.
- `RtData`  in  32  GPR read port 2 (rt); ALU B when `AluSrc`=0; store data.
- `ExtImm`  in  32  extender output; ALU B when `AluSrc`=1.
- `Jump`, `RegDst`, `Branch`, `MemR`, `Mem2R`, `MemW`, `RegW`, `AluSrc`  out  1 each  decoded controls.
- `ExtOp`  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16.
- `AluCtrl`  out  5  ALU operation code.
- `AluResult`  out  32  ALU result.
- `Zero`  out  1  `AluResult`==0.
- `WbData`  out  32  `Mem2R` ? memory read data : `AluResult`.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6 (signed), SLTU 7, SLL 8, SRL 9, SRA 10, SLLV 11, SRLV 12, SRAV 13, PASSB 14, EQ 15.
  - Shifts act on B. SLL/SRL/SRA use `Shamt`; the V forms use A[4:0].
  - SLT/SLTU return 1 or 0. EQ returns 1 if A==B, else 0; this makes `Zero`=1 exactly when A!=B.
  - ADD/SUB wrap modulo 2^32; no overflow trap. Codes 16–31 return 0.
- R-type (op 000000): `RegDst`=1, `RegW`=1, `AluSrc`=0. Funct map:
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT; 101011 SLTU.
  - 000000 SLL; 000010 SRL; 000011 SRA; 000100 SLLV; 000110 SRLV; 000111 SRAV.
  - Unknown funct: all 1-bit controls 0, `AluCtrl`=ADD.
- I-type (all `AluSrc`=1, `RegDst`=0):
  - addi 001000 and addiu 001001: sign-ext, ADD, `RegW`.
  - slti 001010 sign-ext SLT; sltiu 001011 sign-ext SLTU; both `RegW`.
  - andi 001100 AND; ori 001101 OR; xori 001110 XOR; all zero-ext, `RegW`.
  - lui 001111: ExtOp 10, PASSB, `RegW`.
  - lw 100011: sign-ext, ADD, `MemR`, `Mem2R`, `RegW`.
  - sw 101011: sign-ext, ADD, `MemW`.
- Branches (`AluSrc`=0, `Branch`=1, ExtOp 01): beq 000100 uses SUB; bne 000101 uses EQ.
- j 000010: `Jump`=1 only.
- Any other opcode: all controls 0, ExtOp 00, `AluCtrl`=ADD.
- Memory read: combinational; read data = `MemR` ? mem[addr] : 0.

## Timing
- Decode, ALU and read path are purely combinational; zero latency.
- Store: mem[addr] <= `RtData` on rising `Clk` when `MemW`=1.
- Same-cycle read and write to one address: the read returns the old value until the edge.
- `Reset` asserted: all words read 0 immediately; reset overrides a concurrent `MemW`.
- Reset does not affect combinational outputs. Outputs driven by memory contents follow the cleared memory.
- No handshake; one instruction per cycle.

## Structure
- Package `mips_pkg`: opcode and funct constants, ALU code constants (5-bit), ExtOp constants.
- Sub-modules: `mips_decoder` (Ctrl), `mips_alu`, `mips_dmem` (32x32 array with async clear). The top wires them and contains the `AluSrc` and `WbData` muxes.

## Test plan
- addi, op 001000, `RsData`=5, `ExtImm`=0xFFFFFFFD -> `AluCtrl`=0, `AluResult`=2, `RegW`=1, `AluSrc`=1, ExtOp 01, `WbData`=2.
- sw then lw to the same address:
  - sw with `RsData`=4, imm 8, `RtData`=0xDEADBEEF: address 12, written at the edge.
  - lw with the same address -> `WbData`=0xDEADBEEF, `Mem2R`=1.
- Pulse `Reset` mid-run -> address 12 reads 0 with no clock edge needed.
- beq with A=B=7 -> `Zero`=1, `Branch`=1.
- bne with A=7, B=7 -> `Zero`=0; with B=8 -> `Zero`=1.
- sra, `RtData`=0x80000000, `Shamt`=4 -> 0xF8000000.
- sltu with A=1, B=0xFFFFFFFF -> 1; slt with the same operands -> 0.
- lui, `ExtImm`=0x12340000 -> `AluResult`=0x12340000.
- Unknown opcode 111111 -> all controls 0.
